// File: rtl/rv32_pkg.sv
// Shared RV32I encodings and the decoded-operand bundle used by the decode stage.
package rv32_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic        legal;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  func;
      logic        ctrl;
   } decode_t;

endpackage

// File: rtl/rv32_regfile.sv
// 32x32 register file: one write port, two combinational read ports, optional write bypass.
module rv32_regfile #(
   parameter bit BYPASS = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_a_i,
   output logic [31:0] rdata_a_o,
   input  logic [4:0]  raddr_b_i,
   output logic [31:0] rdata_b_o
);

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   always_comb begin
      regs_d = regs_q;
      if (we_i && waddr_i != 5'd0) begin
         regs_d[waddr_i] = wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rdata_a_o = regs_q[raddr_a_i];
      if (raddr_a_i == 5'd0) begin
         rdata_a_o = '0;
      end else if (BYPASS && we_i && waddr_i == raddr_a_i) begin
         rdata_a_o = wdata_i;
      end
   end

   always_comb begin
      rdata_b_o = regs_q[raddr_b_i];
      if (raddr_b_i == 5'd0) begin
         rdata_b_o = '0;
      end else if (BYPASS && we_i && waddr_i == raddr_b_i) begin
         rdata_b_o = wdata_i;
      end
   end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode and operand stage feeding the clocked ALU,
// with a per-register busy scoreboard that stalls read-after-write hazards.
module alu_decode_stage
   import rv32_pkg::*;
#(
   parameter bit BYPASS = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic [31:0] alu_in_A,
   output logic [31:0] alu_in_B,
   output logic [2:0]  func,
   output logic        control,
   output logic        out_valid,
   output logic [4:0]  out_rd,
   output logic        out_wb_en,
   output logic        out_illegal
);

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] rs1_val, rs2_val, u_imm;
   logic        use_rs1, use_rs2, accept;
   decode_t     dec;

   logic [31:0] busy_q, busy_d;
   decode_t     out_q, out_d;
   logic        out_valid_q, out_valid_d;
   logic [4:0]  out_rd_q, out_rd_d;
   logic        out_wb_en_q, out_wb_en_d;

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[11:7];
   assign funct3 = in_instr[14:12];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign funct7 = in_instr[31:25];
   assign u_imm  = {in_instr[31:12], 12'b0};

   rv32_regfile #(
      .BYPASS(BYPASS)
   ) u_regfile (
      .clk_i    (clk),
      .rst_i    (rst),
      .we_i     (wb_en),
      .waddr_i  (wb_rd),
      .wdata_i  (wb_data),
      .raddr_a_i(rs1),
      .rdata_a_o(rs1_val),
      .raddr_b_i(rs2),
      .rdata_b_o(rs2_val)
   );

   always_comb begin
      dec     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            use_rs1  = 1'b1;
            dec.a    = rs1_val;
            dec.func = funct3;
            if (funct3 == F3_SLL) begin
               dec.legal = (funct7 == F7_BASE);
               dec.b     = {27'b0, rs2};
            end else if (funct3 == F3_SR) begin
               dec.legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               dec.b     = {27'b0, rs2};
               dec.ctrl  = in_instr[30];
            end else begin
               dec.legal = 1'b1;
               dec.b     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
         end
         OPC_OP: begin
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            dec.a     = rs1_val;
            dec.func  = funct3;
            dec.ctrl  = (funct3 == F3_SR) && in_instr[30];
            dec.legal = (funct7 == F7_BASE) || (funct7 == F7_ALT && funct3 == F3_SR);
            dec.b     = (funct3 == F3_SLL || funct3 == F3_SR) ? {27'b0, rs2_val[4:0]} : rs2_val;
         end
         OPC_LUI: begin
            dec.legal = 1'b1;
            dec.a     = u_imm;
            dec.ctrl  = 1'b1;
         end
         OPC_AUIPC: begin
            dec.legal = 1'b1;
            dec.a     = in_pc;
            dec.b     = u_imm;
         end
         default: ;
      endcase
      // Illegal instructions still flow down, but with neutral operands.
      if (!dec.legal) begin
         dec = '0;
      end
   end

   // A writeback in flight this cycle satisfies the read only when bypass is enabled.
   always_comb begin
      in_ready = 1'b1;
      if (use_rs1 && busy_q[rs1] && !(BYPASS && wb_en && wb_rd == rs1)) begin
         in_ready = 1'b0;
      end
      if (use_rs2 && busy_q[rs2] && !(BYPASS && wb_en && wb_rd == rs2)) begin
         in_ready = 1'b0;
      end
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_rd] = 1'b0;
      end
      if (accept && dec.legal && rd != 5'd0) begin
         busy_d[rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      out_d       = out_q;
      out_rd_d    = out_rd_q;
      out_wb_en_d = out_wb_en_q;
      out_valid_d = accept;
      if (accept) begin
         out_d       = dec;
         out_rd_d    = rd;
         out_wb_en_d = dec.legal && (rd != 5'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_rd_q    <= '0;
         out_wb_en_q <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_rd_q    <= out_rd_d;
         out_wb_en_q <= out_wb_en_d;
      end
   end

   assign alu_in_A    = out_q.a;
   assign alu_in_B    = out_q.b;
   assign func        = out_q.func;
   assign control     = out_q.ctrl;
   assign out_illegal = out_valid_q ? !out_q.legal : 1'b0;
   assign out_valid   = out_valid_q;
   assign out_rd      = out_rd_q;
   assign out_wb_en   = out_wb_en_q;

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Decode/operand stage directly upstream of the clocked ALU. It accepts one RV32I integer instruction per cycle with a valid/ready handshake and decodes OP, OP-IMM, LUI and AUIPC. It reads a 32×32 register file that it owns, with a writeback port fed from downstream. It drives registered `alu_in_A`, `alu_in_B`, `func` and `control` to the ALU, and uses a per-register busy scoreboard to stall read-after-write hazards.

## Interface
- `BYPASS`, default 1: when 1, a writeback in the same cycle satisfies a read of that register (data forwarded, busy ignored).
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_instr` and `in_pc` are valid.
- `in_ready` out 1: stage accepts this cycle. Combinational.
- `in_instr` in 32: instruction word.
- `in_pc` in 32: PC of the instruction.
- `wb_en` in 1: register writeback strobe.
- `wb_rd` in 5: writeback destination.
- `wb_data` in 32: writeback value.
- `alu_in_A` out 32: operand A (rs1, PC or U-immediate).
- `alu_in_B` out 32: operand B (rs2, immediate or shamt).
- `func` out 3: ALU function (funct3 encoding).
- `control` out 1: LUI pass-through or SRA/SRAI select.
- `out_valid` out 1: output registers hold a new instruction this cycle.
- `out_rd` out 5: destination register.
- `out_wb_en` out 1: the instruction writes `out_rd` (0 if illegal or rd=x0).
- `out_illegal` out 1: instruction was not decodable for this ALU.

## Operation
- Accept when `in_valid && in_ready`. Otherwise `out_valid` is 0 next cycle and the other outputs hold.
- OP-IMM (0010011):
  - A = rs1, B = sign-extended I-immediate, `func` = funct3.
  - SLLI/SRLI/SRAI: B = {27'b0, shamt}. `control` = instr[30] for funct3 101 only.
- OP (0110011):
  - A = rs1, B = rs2, `func` = funct3.
  - Shifts: B = {27'b0, rs2[4:0]}.
  - `control` = instr[30] for SRA.
  - funct7 must be 0000000, or 0100000 for SRA only.
- LUI: A = {imm[31:12], 12'b0}, B = 0, `func` = 000, `control` = 1.
- AUIPC: A = `in_pc`, B = {imm[31:12], 12'b0}, `func` = 000, `control` = 0.
- Illegal: any other opcode, SUB (funct7 0100000 with funct3 000), bad funct7 on OP, or bad instr[31:25] on SLLI/SRLI/SRAI.
  - Still accepted: `out_valid` = 1, `out_illegal` = 1, `out_wb_en` = 0.
  - A, B, `func` and `control` are all 0. No busy bit is set.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Write occurs on posedge when `wb_en`. With BYPASS = 1, the read sees `wb_data` in the same cycle.
- Scoreboard (busy[31:1]):
  - Set for rd on accepting a legal instruction with rd ≠ 0.
  - Cleared on `wb_en` for `wb_rd`.
  - If set and clear hit the same rd in the same cycle, set wins.
- Stall:
  - `in_ready` = 0 when a used source (rs1 for OP/OP-IMM; rs2 for OP only) is busy and not bypassed.
  - LUI and AUIPC never stall.

## Timing
- Latency: accept at edge E0 → outputs valid after E0 → ALU result after E1 → earliest writeback at E2.
  - A dependent instruction waits two stall cycles with BYPASS = 1, three with BYPASS = 0.
- `in_ready` depends combinationally on `in_instr`, the busy bits and `wb_*`. It has no dependence on `in_valid`.
- Reset: all outputs 0, busy cleared, all registers 0, `in_ready` follows the cleared scoreboard.
  - Reset mid-stall discards the pending instruction. Any writeback in the reset cycle is dropped.
- A `wb_en` with `wb_rd` not busy is legal. It writes, and the clear has no effect.

## Structure
- Shared package `rv32_pkg`: opcode constants (OP, OP_IMM, LUI, AUIPC), ALU funct3 constants (ADD, SLL, SLT, SLTU, XOR, SR, OR, AND), funct7 constants.
- Sub-module `rv32_regfile`: 32×32, one write port, two combinational read ports, BYPASS parameter.
- Decode logic, scoreboard and output registers live in the top module.

## Test plan
- After reset, ADDI x1,x0,-5 (0xFFB00093): next cycle A = 0, B = 0xFFFFFFFB, `func` = 000, `control` = 0, `out_rd` = 1, `out_wb_en` = 1.
- LUI x2,0x12345 then AUIPC x3,1 at PC 0x100: A = 0x12345000 with `control` = 1; then A = 0x100, B = 0x1000, `control` = 0.
- SRAI x4,x1,31 and SRA x5,x1,x2 with x2 = 0x25: `func` = 101, `control` = 1, B = 31 and B = 5 respectively.
- SUB x6,x1,x2 (0x40208333), and opcode 0x63: `out_illegal` = 1, `out_wb_en` = 0, a following read of x6 does not stall.
- ADDI x1,x0,7 then ADD x7,x1,x1: `in_ready` is low until `wb_en`/`wb_rd` = 1/`wb_data` = 7 arrives. In that cycle it accepts (BYPASS = 1) and A = B = 7.
- Assert `rst` while stalled on busy x1: next cycle all outputs 0, `in_ready` = 1, x1 reads 0.
